env_voice_alloc: RTL and testbench
==================================

// Module: env_voice_alloc
// PURPOSE
//   Voice allocator/scheduler for a bank of VOICES envseq envelope generators.
//   Accepts note-on/note-off events over a valid/ready handshake, picks an envelope
//   voice, drives its one-clk trigger pulse, and holds per-voice gate and note.
//   Sits between the note/event source and the envseq bank; voice_busy feeds back
//   from the bank.
// PARAMETERS
//   VOICES  4  number of envelope voices managed (>=2)
//   NOTE_W  7  note number width
//   AGE_W   4  per-voice age counter width (saturating)
// PORTS
//   clk          in   1               system clock
//   rst          in   1               synchronous reset, active-high
//   ena          in   1               enable; low freezes FSM and all registers
//   evt_valid    in   1               event present
//   evt_ready    out  1               = (state==IDLE) && ena
//   evt_on       in   1               1 = note-on, 0 = note-off
//   evt_note     in   NOTE_W          event note number
//   voice_busy   in   VOICES          envelope i running (from envseq bank)
//   voice_trig   out  VOICES          one-clk trigger pulse to envelope i
//   voice_gate   out  VOICES          voice i held by a note
//   voice_note   out  VOICES*NOTE_W   note per voice, voice i at [i*NOTE_W +: NOTE_W]
//   alloc_idx    out  $clog2(VOICES)  voice chosen by last note-on
//   alloc_stolen out  1               pulse: last note-on stole a gated voice
//   evt_drop     out  1               pulse: note-on dropped (no voice available)
// BEHAVIOUR
//   Reset: state IDLE; voice_trig, voice_gate, voice_note, ages, alloc_idx,
//     alloc_stolen, evt_drop all 0. rst mid-operation aborts any pending
//     trigger; no trig pulse follows.
//   FSM: IDLE -> ALLOC -> TRIG -> IDLE (note-on); IDLE -> ALLOC -> IDLE
//     (note-off or drop).
//   Cycle N:   evt_valid && evt_ready -> latch evt_on/evt_note, go ALLOC.
//   Cycle N+1 (ALLOC): voice_busy sampled. Note-on target, priority order:
//     1) voice with gate=1 and matching note (retrigger, lowest index)
//     2) free voice (gate=0 && busy=0), lowest index
//     3) steal (see CONFIGURATION)
//   Target: gate<=1, note<=evt_note, age<=0. All other gated voices age+1,
//     saturating at 2^AGE_W-1. alloc_idx<=target; alloc_stolen pulses 1 clk
//     in case 3.
//   Cycle N+2 (TRIG): voice_trig[alloc_idx]=1 for exactly one clk; all others 0.
//     IDLE at N+3.
//   Note-off in ALLOC: clear gate of lowest-index gated voice with matching
//     note; note/age unchanged. No match -> no change. No trig pulse.
//   ena=0: state, outputs, and pulses frozen. A TRIG pulse pending when ena
//     drops is issued when ena returns.
//   voice_trig never has more than one bit set.
// CONFIGURATION
//   VOICE_STEAL_EN defined: case 3 takes the gated voice with the largest age
//     (ties -> lowest index) and re-notes/retriggers it; evt_drop stays 0.
//   Not defined: case 3 drops the event. evt_drop pulses 1 clk in ALLOC, no
//     state change, no trig pulse, FSM returns to IDLE.
// STRUCTURE
//   Package env_pkg: FSM state enum (IDLE/ALLOC/TRIG); VOICE_IDX_W helper
//     function; shared with envseq's ENV_WAITING/ENV_RUNNING constants.
//   Sub-module voice_age_arb: combinational oldest-voice finder (ages, gates
//     -> idx). Instantiated only under VOICE_STEAL_EN.
// TESTING
//   1. Reset, note-on 60 -> evt_ready drops 2 clk; voice_trig=4'b0001 at N+2;
//      gate=0001; alloc_idx=0.
//   2. Note-on 60,62,64 with voice_busy[0]=1 and gate0=0 -> voices 1,2,3
//      allocated; voice 0 skipped.
//   3. Note-on 60 twice -> second retriggers voice 0 (trig 0001); gate count
//      stays 1.
//   4. 4 voices gated, note-on 70: with VOICE_STEAL_EN -> oldest voice 0 stolen,
//      alloc_stolen=1, note0=70. Without it -> evt_drop=1, no trig pulse.
//   5. Note-off 62 -> gate1 cleared, no trig. Note-off 99 (unmatched) -> no
//      register change.
//   6. rst asserted in ALLOC -> no trig pulse, all gates 0; ena=0 in TRIG ->
//      pulse deferred until ena=1.

Source files
------------

// File: rtl/env_pkg.sv
// Shared definitions for the envelope voice allocator and the envseq bank:
// allocator FSM states, envelope busy-flag meaning, and an index-width helper.
package env_pkg;

    // Allocator FSM: IDLE accepts an event, ALLOC picks/updates a voice,
    // TRIG drives the one-clock trigger pulse.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALLOC = 2'd1,
        ST_TRIG  = 2'd2
    } alloc_state_t;

    // Meaning of an envseq voice_busy bit.
    localparam logic ENV_WAITING = 1'b0;
    localparam logic ENV_RUNNING = 1'b1;

    // Width of a voice index; never narrower than one bit.
    function automatic int VOICE_IDX_W(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/voice_age_arb.sv
// Combinational oldest-voice finder: among gated voices, returns the one with
// the largest age; ties resolve to the lowest index. Used for voice stealing.
module voice_age_arb #(
    parameter int VOICES = 4,
    parameter int AGE_W  = 4,
    parameter int IDX_W  = 2
) (
    input  logic [VOICES*AGE_W-1:0] ages,
    input  logic [VOICES-1:0]       gates,
    output logic [IDX_W-1:0]        idx
);

    logic             found;
    logic [AGE_W-1:0] best_age;

    // Linear scan; strict '>' keeps the earlier (lower) index on equal ages.
    always_comb begin
        found    = 1'b0;
        best_age = '0;
        idx      = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (gates[i] && (!found || ages[i*AGE_W +: AGE_W] > best_age)) begin
                found    = 1'b1;
                best_age = ages[i*AGE_W +: AGE_W];
                idx      = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/env_voice_alloc.sv
// Voice allocator for a bank of envseq envelope generators.
// Handshake: an event transfers on a clock edge where evt_valid && evt_ready;
// evt_ready is high only in IDLE while ena is high, and the source must hold
// evt_on/evt_note stable while evt_valid is high and not yet accepted.
// Optional feature macro VOICE_STEAL_EN: when defined, a note-on with no free
// voice steals the oldest gated voice; otherwise such a note-on is dropped.
module env_voice_alloc
    import env_pkg::*;
#(
    parameter int VOICES = 4,
    parameter int NOTE_W = 7,
    parameter int AGE_W  = 4,
    localparam int IDX_W = VOICE_IDX_W(VOICES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic                     evt_valid,
    output logic                     evt_ready,
    input  logic                     evt_on,
    input  logic [NOTE_W-1:0]        evt_note,
    input  logic [VOICES-1:0]        voice_busy,
    output logic [VOICES-1:0]        voice_trig,
    output logic [VOICES-1:0]        voice_gate,
    output logic [VOICES*NOTE_W-1:0] voice_note,
    output logic [IDX_W-1:0]         alloc_idx,
    output logic                     alloc_stolen,
    output logic                     evt_drop,
    output logic [1:0]               dbg_state
);

    alloc_state_t             state_q, state_d;
    logic                     on_q, on_d;
    logic [NOTE_W-1:0]        enote_q, enote_d;
    logic [VOICES-1:0]        gate_q, gate_d;
    logic [VOICES*NOTE_W-1:0] vnote_q, vnote_d;
    logic [AGE_W-1:0]         age_q [VOICES];
    logic [AGE_W-1:0]         age_d [VOICES];
    logic [IDX_W-1:0]         alloc_idx_q, alloc_idx_d;
    logic                     stolen_q, stolen_d;
    logic                     drop_q, drop_d;

    logic                     hit_found, free_found;
    logic [IDX_W-1:0]         hit_idx, free_idx, old_idx;

`ifdef VOICE_STEAL_EN
    logic [VOICES*AGE_W-1:0]  ages_flat;

    // Flatten ages for the oldest-voice arbiter.
    always_comb begin
        ages_flat = '0;
        for (int i = 0; i < VOICES; i++) ages_flat[i*AGE_W +: AGE_W] = age_q[i];
    end

    voice_age_arb #(.VOICES(VOICES), .AGE_W(AGE_W), .IDX_W(IDX_W)) u_age_arb (
        .ages  (ages_flat),
        .gates (gate_q),
        .idx   (old_idx)
    );
`else
    assign old_idx = '0;
`endif

    // Lowest-index gated voice holding the latched note, and lowest free voice.
    always_comb begin
        hit_found  = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (!hit_found && gate_q[i] && vnote_q[i*NOTE_W +: NOTE_W] == enote_q) begin
                hit_found = 1'b1;
                hit_idx   = IDX_W'(i);
            end
            if (!free_found && !gate_q[i] && voice_busy[i] != ENV_RUNNING) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Next-state and register updates; ena low holds everything including pulses.
    always_comb begin
        logic             do_alloc;
        logic             do_steal;
        logic [IDX_W-1:0] target;
        state_d     = state_q;
        on_d        = on_q;
        enote_d     = enote_q;
        gate_d      = gate_q;
        vnote_d     = vnote_q;
        age_d       = age_q;
        alloc_idx_d = alloc_idx_q;
        stolen_d    = 1'b0;
        drop_d      = 1'b0;
        do_alloc    = 1'b0;
        do_steal    = 1'b0;
        target      = '0;
        if (!ena) begin
            stolen_d = stolen_q;
            drop_d   = drop_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (evt_valid) begin
                        on_d    = evt_on;
                        enote_d = evt_note;
                        state_d = ST_ALLOC;
                    end
                end
                ST_ALLOC: begin
                    state_d = ST_IDLE;
                    if (on_q) begin
                        if (hit_found) begin
                            do_alloc = 1'b1;
                            target   = hit_idx;
                        end else if (free_found) begin
                            do_alloc = 1'b1;
                            target   = free_idx;
                        end else begin
`ifdef VOICE_STEAL_EN
                            do_alloc = 1'b1;
                            do_steal = 1'b1;
                            target   = old_idx;
`endif
                        end
                        if (do_alloc) begin
                            for (int i = 0; i < VOICES; i++) begin
                                if (IDX_W'(i) == target) begin
                                    gate_d[i]                   = 1'b1;
                                    vnote_d[i*NOTE_W +: NOTE_W] = enote_q;
                                    age_d[i]                    = '0;
                                end else if (gate_q[i] && age_q[i] != {AGE_W{1'b1}}) begin
                                    age_d[i] = age_q[i] + 1'b1;
                                end
                            end
                            alloc_idx_d = target;
                            stolen_d    = do_steal;
                            state_d     = ST_TRIG;
                        end else begin
                            drop_d = 1'b1;
                        end
                    end else if (hit_found) begin
                        gate_d[hit_idx] = 1'b0;
                    end
                end
                ST_TRIG: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            on_q        <= 1'b0;
            enote_q     <= '0;
            gate_q      <= '0;
            vnote_q     <= '0;
            age_q       <= '{default: '0};
            alloc_idx_q <= '0;
            stolen_q    <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            on_q        <= on_d;
            enote_q     <= enote_d;
            gate_q      <= gate_d;
            vnote_q     <= vnote_d;
            age_q       <= age_d;
            alloc_idx_q <= alloc_idx_d;
            stolen_q    <= stolen_d;
            drop_q      <= drop_d;
        end
    end

    // Trigger is a one-hot pulse in TRIG, withheld while ena is low.
    always_comb begin
        voice_trig = '0;
        if (state_q == ST_TRIG && ena) voice_trig[alloc_idx_q] = 1'b1;
    end

    assign evt_ready    = (state_q == ST_IDLE) && ena;
    assign voice_gate   = gate_q;
    assign voice_note   = vnote_q;
    assign alloc_idx    = alloc_idx_q;
    assign alloc_stolen = stolen_q;
    assign evt_drop     = drop_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_env_voice_alloc.sv
// Directed bench for env_voice_alloc (VOICES=4, NOTE_W=7, AGE_W=4).
module tb_env_voice_alloc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b1;
    logic        evt_valid = 1'b0;
    logic        evt_ready;
    logic        evt_on = 1'b0;
    logic [6:0]  evt_note = '0;
    logic [3:0]  voice_busy = '0;
    logic [3:0]  voice_trig;
    logic [3:0]  voice_gate;
    logic [27:0] voice_note;
    logic [1:0]  alloc_idx;
    logic        alloc_stolen;
    logic        evt_drop;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    env_voice_alloc #(.VOICES(4), .NOTE_W(7), .AGE_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_on       (evt_on),
        .evt_note     (evt_note),
        .voice_busy   (voice_busy),
        .voice_trig   (voice_trig),
        .voice_gate   (voice_gate),
        .voice_note   (voice_note),
        .alloc_idx    (alloc_idx),
        .alloc_stolen (alloc_stolen),
        .evt_drop     (evt_drop),
        .dbg_state    (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // All driving/sampling happens 1 ns after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; ena = 1'b1; evt_valid = 1'b0; voice_busy = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Hand one event over; returns in the cycle after acceptance (ALLOC).
    task automatic send_evt(input logic on, input logic [6:0] note);
        int n = 0;
        while (evt_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (evt_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL ready_timeout: evt_ready=%b required 1", evt_ready);
        end
        evt_valid = 1'b1; evt_on = on; evt_note = note;
        tick();
        evt_valid = 1'b0;
    endtask

    // Note-on that runs to completion (ALLOC, TRIG, back to IDLE).
    task automatic note_on_full(input logic [6:0] note);
        send_evt(1'b1, note);
        tick();
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (evt_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", evt_ready); end
        checks++; if (voice_trig !== 4'b0000) begin errors++; $display("FAIL reset_trig: got %b want 0000", voice_trig); end
        checks++; if (voice_gate !== 4'b0000) begin errors++; $display("FAIL reset_gate: got %b want 0000", voice_gate); end
        checks++; if (voice_note !== 28'd0) begin errors++; $display("FAIL reset_note: got %h want 0", voice_note); end
        checks++; if (alloc_idx !== 2'd0 || alloc_stolen !== 1'b0 || evt_drop !== 1'b0) begin
            errors++; $display("FAIL reset_flags: idx=%0d stolen=%b drop=%b want 0 0 0", alloc_idx, alloc_stolen, evt_drop);
        end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    endtask

    task automatic test_note_on();
        apply_reset();
        send_evt(1'b1, 7'd60);
        checks++; if (evt_ready !== 1'b0 || voice_trig !== 4'b0000) begin
            errors++; $display("FAIL on_alloc: ready=%b trig=%b want 0 0000", evt_ready, voice_trig);
        end
        tick();
        checks++; if (evt_ready !== 1'b0) begin errors++; $display("FAIL on_trig_ready: got %b want 0", evt_ready); end
        checks++; if (voice_trig !== 4'b0001) begin errors++; $display("FAIL on_trig: got %b want 0001", voice_trig); end
        checks++; if (voice_gate !== 4'b0001 || alloc_idx !== 2'd0) begin
            errors++; $display("FAIL on_gate_idx: gate=%b idx=%0d want 0001 0", voice_gate, alloc_idx);
        end
        checks++; if (voice_note[6:0] !== 7'd60) begin errors++; $display("FAIL on_note0: got %0d want 60", voice_note[6:0]); end
        tick();
        checks++; if (evt_ready !== 1'b1 || voice_trig !== 4'b0000) begin
            errors++; $display("FAIL on_end: ready=%b trig=%b want 1 0000", evt_ready, voice_trig);
        end
    endtask

    task automatic test_busy_skip();
        logic [6:0] notes [3];
        logic [3:0] trig_exp [3];
        notes    = '{7'd60, 7'd62, 7'd64};
        trig_exp = '{4'b0010, 4'b0100, 4'b1000};
        apply_reset();
        voice_busy = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            send_evt(1'b1, notes[k]);
            tick();
            checks++; if (voice_trig !== trig_exp[k] || alloc_idx !== 2'(k + 1)) begin
                errors++; $display("FAIL busy_alloc%0d: trig=%b idx=%0d want %b %0d", k, voice_trig, alloc_idx, trig_exp[k], k + 1);
            end
            tick();
        end
        checks++; if (voice_gate !== 4'b1110) begin errors++; $display("FAIL busy_gate: got %b want 1110", voice_gate); end
        voice_busy = '0;
    endtask

    task automatic test_retrigger();
        apply_reset();
        note_on_full(7'd60);
        send_evt(1'b1, 7'd60);
        tick();
        checks++; if (voice_trig !== 4'b0001 || alloc_idx !== 2'd0) begin
            errors++; $display("FAIL retrig: trig=%b idx=%0d want 0001 0", voice_trig, alloc_idx);
        end
        checks++; if (voice_gate !== 4'b0001) begin errors++; $display("FAIL retrig_gate: got %b want 0001", voice_gate); end
        tick();
    endtask

    task automatic test_full();
        apply_reset();
        note_on_full(7'd60);
        note_on_full(7'd62);
        note_on_full(7'd64);
        note_on_full(7'd66);
        checks++; if (voice_gate !== 4'b1111) begin errors++; $display("FAIL full_gate: got %b want 1111", voice_gate); end
        send_evt(1'b1, 7'd70);
        tick();
`ifdef VOICE_STEAL_EN
        checks++; if (voice_trig !== 4'b0001 || alloc_stolen !== 1'b1 || evt_drop !== 1'b0) begin
            errors++; $display("FAIL steal: trig=%b stolen=%b drop=%b want 0001 1 0", voice_trig, alloc_stolen, evt_drop);
        end
        checks++; if (voice_note[6:0] !== 7'd70) begin errors++; $display("FAIL steal_note0: got %0d want 70", voice_note[6:0]); end
        tick();
        checks++; if (alloc_stolen !== 1'b0) begin errors++; $display("FAIL steal_pulse: got %b want 0", alloc_stolen); end
        send_evt(1'b1, 7'd72);
        tick();
        checks++; if (voice_trig !== 4'b0010 || alloc_idx !== 2'd1) begin
            errors++; $display("FAIL steal2: trig=%b idx=%0d want 0010 1", voice_trig, alloc_idx);
        end
        tick();
`else
        checks++; if (evt_drop !== 1'b1 || alloc_stolen !== 1'b0 || voice_trig !== 4'b0000) begin
            errors++; $display("FAIL drop: drop=%b stolen=%b trig=%b want 1 0 0000", evt_drop, alloc_stolen, voice_trig);
        end
        checks++; if (voice_note[6:0] !== 7'd60 || alloc_idx !== 2'd3 || voice_gate !== 4'b1111) begin
            errors++; $display("FAIL drop_hold: note0=%0d idx=%0d gate=%b want 60 3 1111", voice_note[6:0], alloc_idx, voice_gate);
        end
        checks++; if (evt_ready !== 1'b1) begin errors++; $display("FAIL drop_ready: got %b want 1", evt_ready); end
        tick();
        checks++; if (evt_drop !== 1'b0 || voice_trig !== 4'b0000) begin
            errors++; $display("FAIL drop_pulse: drop=%b trig=%b want 0 0000", evt_drop, voice_trig);
        end
`endif
    endtask

    task automatic test_note_off();
        apply_reset();
        note_on_full(7'd60);
        note_on_full(7'd62);
        note_on_full(7'd64);
        send_evt(1'b0, 7'd62);
        checks++; if (voice_trig !== 4'b0000) begin errors++; $display("FAIL off_alloc_trig: got %b want 0000", voice_trig); end
        tick();
        checks++; if (voice_gate !== 4'b0101 || voice_trig !== 4'b0000 || evt_ready !== 1'b1) begin
            errors++; $display("FAIL off62: gate=%b trig=%b ready=%b want 0101 0000 1", voice_gate, voice_trig, evt_ready);
        end
        send_evt(1'b0, 7'd99);
        tick();
        checks++; if (voice_gate !== 4'b0101 || voice_note !== {7'd0, 7'd64, 7'd62, 7'd60} || alloc_idx !== 2'd2) begin
            errors++; $display("FAIL off99: gate=%b note=%h idx=%0d want 0101 %h 2", voice_gate, voice_note, alloc_idx, {7'd0, 7'd64, 7'd62, 7'd60});
        end
    endtask

    task automatic test_rst_in_alloc();
        apply_reset();
        send_evt(1'b1, 7'd60);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (voice_trig !== 4'b0000 || voice_gate !== 4'b0000) begin
                errors++; $display("FAIL rst_alloc%0d: trig=%b gate=%b want 0000 0000", k, voice_trig, voice_gate);
            end
            tick();
        end
    endtask

    task automatic test_ena_defer();
        apply_reset();
        send_evt(1'b1, 7'd61);
        tick();
        ena = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (voice_trig !== 4'b0000 || evt_ready !== 1'b0) begin
                errors++; $display("FAIL ena_hold%0d: trig=%b ready=%b want 0000 0", k, voice_trig, evt_ready);
            end
            tick();
        end
        ena = 1'b1;
        #1;
        checks++; if (voice_trig !== 4'b0001) begin errors++; $display("FAIL ena_resume: got %b want 0001", voice_trig); end
        tick();
        checks++; if (voice_trig !== 4'b0000 || evt_ready !== 1'b1) begin
            errors++; $display("FAIL ena_after: trig=%b ready=%b want 0000 1", voice_trig, evt_ready);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_note_on();
        test_busy_skip();
        test_retrigger();
        test_full();
        test_note_off();
        test_rst_in_alloc();
        test_ena_defer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
